// File: rtl/fetch_pc_unit_pkg.sv
// Shared types and constants for the instruction-fetch program-counter unit.
// Holds the fetch FSM state encoding and the reset/boot values.
package fetch_pc_unit_pkg;

  typedef logic [31:0] data_t;
  typedef logic [31:0] instr_t;

  typedef enum logic [2:0] {
    BOOT,
    REQ,
    WAIT,
    DROP,
    HALT
  } fetch_state_t;

  // addi x0, x0, 0
  localparam instr_t NOP_INSTR       = 32'h0000_0013;
  localparam data_t  DEFAULT_BOOT_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_unit_skid_buf.sv
// One-entry {pc, instr} holding buffer used when IF/ID is stalled while a
// fetch response lands. Clear wins over load, load wins over drain.
module fetch_skid_buf
  import fetch_pc_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            drain_i,
  input  logic            clear_i,
  input  logic [XLEN-1:0] pc_i,
  input  instr_t          instr_i,
  output logic            full_o,
  output logic [XLEN-1:0] pc_o,
  output instr_t          instr_o
);

  logic            full_q, full_d;
  logic [XLEN-1:0] pc_q, pc_d;
  instr_t          instr_q, instr_d;

  always_comb begin
    full_d  = full_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (clear_i) begin
      full_d = 1'b0;
    end else if (load_i) begin
      full_d  = 1'b1;
      pc_d    = pc_i;
      instr_d = instr_i;
    end else if (drain_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q  <= 1'b0;
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
    end else begin
      full_q  <= full_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign full_o  = full_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-side PC owner: issues one outstanding instruction-memory request at a
// time, presents {pc, instr} to IF/ID and squashes wrong-path fetches on redirect.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter int              XLEN    = 32,
  parameter logic [XLEN-1:0] BOOT_PC = XLEN'(DEFAULT_BOOT_PC)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_valid_o,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_req_ready_i,
  input  logic            imem_rsp_valid_i,
  input  instr_t          imem_rsp_data_i,
  output logic            if_valid_o,
  output logic [XLEN-1:0] if_pc_o,
  output instr_t          if_instr_o,
  output logic            flush_o,
  output logic            misalign_o
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  instr_t          out_instr_q, out_instr_d;
  logic            misalign_q, misalign_d;

  logic            skid_full;
  logic [XLEN-1:0] skid_pc;
  instr_t          skid_instr;
  logic            skid_load, skid_drain, skid_clear;

  logic redirect_eff;
  logic target_misaligned;
  logic consume;
  logic rsp_take;

  assign redirect_eff      = redirect_i & ~stall_i & (state_q != HALT);
  assign target_misaligned = (redirect_pc_i[1:0] != 2'b00);
  assign consume           = out_valid_q & ~stall_i;
  // With the skid full nothing is outstanding, so a response here is always ours.
  assign rsp_take          = (state_q == WAIT) & ~skid_full & imem_rsp_valid_i;

  fetch_skid_buf #(
    .XLEN (XLEN)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (skid_load),
    .drain_i (skid_drain),
    .clear_i (skid_clear),
    .pc_i    (pc_q),
    .instr_i (imem_rsp_data_i),
    .full_o  (skid_full),
    .pc_o    (skid_pc),
    .instr_o (skid_instr)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    misalign_d  = misalign_q;
    skid_load   = 1'b0;
    skid_drain  = 1'b0;
    skid_clear  = 1'b0;

    if (redirect_eff) begin
      out_valid_d = 1'b0;
      skid_clear  = 1'b1;
      if (target_misaligned) begin
        state_d    = HALT;
        misalign_d = 1'b1;
      end else begin
        pc_d = redirect_pc_i;
        // Go to DROP only when a wrong-path response is still owed to us.
        case (state_q)
          REQ:     state_d = imem_req_ready_i ? DROP : REQ;
          WAIT:    state_d = (imem_rsp_valid_i || skid_full) ? REQ : DROP;
          DROP:    state_d = imem_rsp_valid_i ? REQ : DROP;
          default: state_d = REQ;
        endcase
      end
    end else begin
      if (consume) begin
        if (skid_full) begin
          out_pc_d    = skid_pc;
          out_instr_d = skid_instr;
          skid_drain  = 1'b1;
        end else begin
          out_valid_d = 1'b0;
        end
      end

      if (rsp_take) begin
        pc_d = pc_q + XLEN'(4);
        if (!out_valid_q || consume) begin
          out_valid_d = 1'b1;
          out_pc_d    = pc_q;
          out_instr_d = imem_rsp_data_i;
        end else begin
          skid_load = 1'b1;
        end
      end

      case (state_q)
        BOOT: state_d = REQ;
        REQ: begin
          if (imem_req_ready_i) state_d = WAIT;
        end
        WAIT: begin
          if (skid_full) begin
            if (consume) state_d = REQ;
          end else if (imem_rsp_valid_i) begin
            state_d = (out_valid_q && !consume) ? WAIT : REQ;
          end
        end
        DROP: begin
          if (imem_rsp_valid_i) state_d = REQ;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= BOOT;
      pc_q        <= BOOT_PC;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_instr_q <= NOP_INSTR;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
      misalign_q  <= misalign_d;
    end
  end

  assign imem_req_valid_o = (state_q == REQ);
  assign imem_req_addr_o  = pc_q;
  assign if_valid_o       = out_valid_q;
  assign if_pc_o          = out_pc_q;
  assign if_instr_o       = out_instr_q;
  assign flush_o          = redirect_eff;
  assign misalign_o       = misalign_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Randomised bench for fetch_pc_unit: an instruction-memory responder plus a
// queue-based fetch model checked against the DUT every cycle.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, redirect, req_ready, rsp_valid;
  logic [31:0] redirect_pc, rsp_data;
  logic        req_valid, if_valid, flush, misalign;
  logic [31:0] req_addr, if_pc, if_instr;

  always #5 clk = ~clk;

  fetch_pc_unit #(.XLEN(32), .BOOT_PC(32'h0000_0000)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall_i          (stall),
    .redirect_i       (redirect),
    .redirect_pc_i    (redirect_pc),
    .imem_req_valid_o (req_valid),
    .imem_req_addr_o  (req_addr),
    .imem_req_ready_i (req_ready),
    .imem_rsp_valid_i (rsp_valid),
    .imem_rsp_data_i  (rsp_data),
    .if_valid_o       (if_valid),
    .if_pc_o          (if_pc),
    .if_instr_o       (if_instr),
    .flush_o          (flush),
    .misalign_o       (misalign)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  // Behavioural model: fetch whenever nothing is in flight and the IF/ID
  // output plus one spare slot (a 2-deep queue) has room.
  ent_t        pres[$];
  logic [31:0] m_pc;
  bit          m_boot, m_need_req, m_outstanding, m_drop, m_halted, m_misal;

  // Instruction memory environment.
  bit          mem_pend;
  int          mem_cnt;
  logic [31:0] mem_addr;
  int          max_lat = 1;

  // Samples from the latest step, for literal checks.
  logic        s_req_valid, s_if_valid, s_flush, s_misalign;
  logic [31:0] s_req_addr, s_if_pc, s_if_instr;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    pres.delete();
    m_pc = 32'h0; m_boot = 1; m_need_req = 0; m_outstanding = 0;
    m_drop = 0; m_halted = 0; m_misal = 0;
    mem_pend = 0; mem_cnt = 0; mem_addr = 0;
    cyc = 0;
  endtask

  // One clock cycle: drive at the negedge, check #1 later, advance model.
  task automatic step(input int p_rdy, input int p_stl, input int p_red,
                      input logic [31:0] red_pc, input bit rand_pc);
    bit eff, acc, rsp_here;
    rsp_valid = 1'b0;
    rsp_data  = 32'h0;
    if (mem_pend) begin
      if (mem_cnt == 0) begin
        rsp_valid = 1'b1;
        rsp_data  = mem_data(mem_addr);
        mem_pend  = 0;
      end else begin
        mem_cnt--;
      end
    end
    req_ready = ($urandom_range(0, 99) < p_rdy);
    stall     = ($urandom_range(0, 99) < p_stl);
    redirect  = ($urandom_range(0, 99) < p_red);
    if (rand_pc) redirect_pc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC
                                                          : {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
    else         redirect_pc = red_pc;
    #1;
    s_req_valid = req_valid; s_req_addr = req_addr; s_if_valid = if_valid;
    s_if_pc = if_pc; s_if_instr = if_instr; s_flush = flush; s_misalign = misalign;

    eff = redirect && !stall && !m_halted;
    chk("flush", {31'h0, flush}, {31'h0, eff});
    chk("misalign", {31'h0, misalign}, {31'h0, m_misal});
    chk("req_valid", {31'h0, req_valid}, {31'h0, m_need_req});
    if (m_need_req) chk("req_addr", req_addr, m_pc);
    chk("if_valid", {31'h0, if_valid}, {31'h0, pres.size() > 0});
    if (pres.size() > 0) begin
      chk("if_pc", if_pc, pres[0].pc);
      chk("if_instr", if_instr, pres[0].instr);
    end

    acc      = m_need_req && req_ready;
    rsp_here = rsp_valid && m_outstanding;
    if (acc) begin
      mem_pend = 1;
      mem_cnt  = $urandom_range(1, max_lat) - 1;
      mem_addr = m_pc;
    end

    if (eff) begin
      pres.delete();
      m_boot = 0;
      if (redirect_pc[1:0] != 2'b00) begin
        m_halted = 1; m_misal = 1; m_need_req = 0; m_outstanding = 0; m_drop = 0;
      end else begin
        m_pc = redirect_pc;
        if (acc) begin
          m_outstanding = 1; m_drop = 1; m_need_req = 0;
        end else if (m_outstanding && !rsp_here) begin
          m_drop = 1; m_need_req = 0;
        end else begin
          m_outstanding = 0; m_drop = 0; m_need_req = 1;
        end
      end
    end else if (!m_halted) begin
      if (pres.size() > 0 && !stall) begin
        $display("[TB] cyc %0d fetched pc=%h instr=%h", cyc, pres[0].pc, pres[0].instr);
        void'(pres.pop_front());
      end
      if (m_boot) begin
        m_boot = 0;
      end else if (acc) begin
        m_need_req = 0; m_outstanding = 1;
      end else if (rsp_here) begin
        m_outstanding = 0;
        if (m_drop) m_drop = 0;
        else begin
          pres.push_back('{pc: m_pc, instr: rsp_data});
          m_pc = m_pc + 32'd4;
        end
      end
      if (!m_outstanding) m_need_req = (pres.size() < 2);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_ready = 0; rsp_valid = 0; stall = 0; redirect = 0;
    redirect_pc = 0; rsp_data = 0;
    #1;
    chk("rst_req_valid", {31'h0, req_valid}, 32'h0);
    chk("rst_req_addr", req_addr, 32'h0);
    chk("rst_if_valid", {31'h0, if_valid}, 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0000_0013);
    chk("rst_misalign", {31'h0, misalign}, 32'h0);
    chk("rst_flush", {31'h0, flush}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    bit found;
    rst_n = 1'b1; stall = 0; redirect = 0; redirect_pc = 0;
    req_ready = 0; rsp_valid = 0; rsp_data = 0;
    #2;
    do_reset();

    // Boot sequence: ready=1, latency 1, no stall.
    max_lat = 1;
    for (int c = 0; c < 7; c++) begin
      step(100, 0, 0, 32'h0, 0);
      chk("boot_req_valid", {31'h0, s_req_valid}, {31'h0, c == 1 || c == 3 || c == 5});
      chk("boot_if_valid", {31'h0, s_if_valid}, {31'h0, c == 3 || c == 5});
      if (c == 1) chk("boot_addr0", s_req_addr, 32'h0);
      if (c == 3) chk("boot_addr4", s_req_addr, 32'h4);
      if (c == 5) chk("boot_addr8", s_req_addr, 32'h8);
      if (c == 3) chk("boot_ifpc0", s_if_pc, 32'h0);
      if (c == 5) chk("boot_ifpc4", s_if_pc, 32'h4);
      if (c == 3) chk("boot_instr0", s_if_instr, mem_data(32'h0));
    end

    // Request held while not ready.
    for (int c = 0; c < 4; c++) begin
      step((c == 3) ? 100 : 0, 0, 0, 32'h0, 0);
      chk("hold_valid", {31'h0, s_req_valid}, 32'h1);
      chk("hold_addr", s_req_addr, 32'hC);
      if (c == 0) chk("hold_ifpc8", s_if_pc, 32'h8);
    end

    // Redirect ignored under stall, then taken.
    step(100, 100, 100, 32'h200, 0);
    chk("stall_redir_flush", {31'h0, s_flush}, 32'h0);
    step(100, 0, 100, 32'h200, 0);
    chk("redir_flush", {31'h0, s_flush}, 32'h1);
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      step(100, 0, 0, 32'h0, 0);
      if (s_if_valid) begin
        found = 1;
        chk("redir_ifpc", s_if_pc, 32'h200);
      end
    end
    chk("redir_timeout", {31'h0, found}, 32'h1);

    // Randomised traffic.
    max_lat = 3;
    for (int c = 0; c < 2000; c++) step(70, 25, 8, 32'h0, 1);

    // Misaligned redirect halts fetch for good.
    step(100, 0, 100, 32'h102, 0);
    chk("mis_flush", {31'h0, s_flush}, 32'h1);
    for (int c = 0; c < 20; c++) begin
      step(70, 25, 20, 32'h0, 1);
      chk("mis_sticky", {31'h0, s_misalign}, 32'h1);
      chk("mis_noreq", {31'h0, s_req_valid}, 32'h0);
    end

    // Reset while a fetch is in flight.
    do_reset();
    step(100, 0, 0, 32'h0, 0);
    max_lat = 3;
    step(100, 0, 0, 32'h0, 0);
    do_reset();
    max_lat = 1;
    step(100, 0, 0, 32'h0, 0);
    step(100, 0, 0, 32'h0, 0);
    chk("restart_req", {31'h0, s_req_valid}, 32'h1);
    chk("restart_addr", s_req_addr, 32'h0);

    max_lat = 3;
    for (int c = 0; c < 1500; c++) step(60, 40, 10, 32'h0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
